encrypt: RTL and testbench

ENCRYPT -- requirements
Module: encrypt

---
 rtl/fhe_params_pkg.sv | 26 ++
 rtl/encrypt_accum.sv | 41 ++++
 rtl/encrypt.sv | 134 +++++++++++++
 tb/tb_encrypt.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fhe_params_pkg.sv
// Shared parameter defaults and FSM state encoding for the encrypt/decrypt datapaths.
package fhe_params_pkg;

  localparam int DEF_PLAINTEXT_MODULUS  = 64;
  localparam int DEF_PLAINTEXT_WIDTH    = 6;
  localparam int DEF_DIMENSION          = 1;
  localparam int DEF_CIPHERTEXT_MODULUS = 1024;
  localparam int DEF_CIPHERTEXT_WIDTH   = 10;
  localparam int DEF_BIG_N              = 30;

  // Scaling factor that lifts a plaintext into the top bits of a ciphertext lane.
  localparam int DELTA = DEF_CIPHERTEXT_MODULUS / DEF_PLAINTEXT_MODULUS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fhe_state_e;

  // With power-of-two moduli, multiplying by DELTA is a left shift by this amount.
  function automatic int delta_shift(input int ct_width, input int pt_width);
    return ct_width - pt_width;
  endfunction

endpackage

// File: rtl/encrypt_accum.sv
// Multi-lane mod-q accumulator: lanes wrap naturally at W bits because q = 2^W.
module encrypt_accum #(
  parameter int LANES = 2,
  parameter int W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_i,
  input  logic [W-1:0]       init_lane0_i,
  input  logic               add_i,
  input  logic [LANES*W-1:0] row_i,
  output logic [LANES*W-1:0] sum_o
);

  logic [LANES*W-1:0] acc_q, acc_d;

  // sum_o is the value the accumulator takes this edge unless it is being initialised.
  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_o[l*W +: W] = acc_q[l*W +: W] + (add_i ? row_i[l*W +: W] : {W{1'b0}});
    end
  end

  always_comb begin
    acc_d = sum_o;
    if (init_i) begin
      acc_d          = '0;
      acc_d[W-1:0]   = init_lane0_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/encrypt.sv
// LWE-style encryption: sums the public-key rows picked by subset and adds DELTA*m to lane 0.
// Optional feature macro ENCRYPT_NOISE_EN adds a signed 4-bit noise input folded into lane 0.
module encrypt
  import fhe_params_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = DEF_PLAINTEXT_MODULUS,
  parameter int PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
  parameter int DIMENSION          = DEF_DIMENSION,
  parameter int CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
  parameter int CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
  parameter int BIG_N              = DEF_BIG_N
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [PLAINTEXT_WIDTH-1:0]                  plaintext,
  input  logic [BIG_N-1:0]                            subset,
`ifdef ENCRYPT_NOISE_EN
  input  logic signed [3:0]                           noise,
`endif
  output logic [$clog2(BIG_N)-1:0]                    pk_addr,
  output logic                                        pk_rd_en,
  input  logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0]   pk_data,
  output logic                                        busy,
  output logic                                        done,
  output logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0]   cipher_text
);

  localparam int LANES = DIMENSION + 1;
  localparam int W     = CIPHERTEXT_WIDTH;
  localparam int AW    = $clog2(BIG_N);
  localparam int SHIFT = delta_shift(CIPHERTEXT_WIDTH, PLAINTEXT_WIDTH);
  localparam logic [AW-1:0] LAST_ROW = AW'(BIG_N - 1);

  fhe_state_e          state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [BIG_N-1:0]    subset_q, subset_d;
  logic                sel_q, sel_d;
  logic [LANES*W-1:0]  cipher_q, cipher_d;

  logic                acc_init;
  logic                acc_add;
  logic [W-1:0]        init_lane0;
  logic [LANES*W-1:0]  acc_sum;

`ifdef ENCRYPT_NOISE_EN
  logic signed [W-1:0] noise_ext;
  assign noise_ext  = W'(noise);
  assign init_lane0 = (W'(plaintext) << SHIFT) + $unsigned(noise_ext);
`else
  assign init_lane0 = W'(plaintext) << SHIFT;
`endif

  // sel_q remembers whether the row addressed last cycle was selected, since its data
  // arrives one cycle after the read strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    subset_d = subset_q;
    sel_d    = 1'b0;
    cipher_d = cipher_q;
    acc_init = 1'b0;
    acc_add  = 1'b0;
    pk_rd_en = 1'b0;
    pk_addr  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          subset_d = subset;
          acc_init = 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        pk_rd_en = 1'b1;
        pk_addr  = cnt_q;
        sel_d    = subset_q[cnt_q];
        acc_add  = sel_q;
        if (cnt_q == LAST_ROW) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        busy     = 1'b1;
        acc_add  = sel_q;
        cipher_d = acc_sum;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      subset_q <= '0;
      sel_q    <= 1'b0;
      cipher_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      subset_q <= subset_d;
      sel_q    <= sel_d;
      cipher_q <= cipher_d;
    end
  end

  assign cipher_text = cipher_q;

  encrypt_accum #(
    .LANES (LANES),
    .W     (W)
  ) u_accum (
    .clk          (clk),
    .rst          (rst),
    .init_i       (acc_init),
    .init_lane0_i (init_lane0),
    .add_i        (acc_add),
    .row_i        (pk_data),
    .sum_o        (acc_sum)
  );

endmodule

// File: tb/tb_encrypt.sv
// Directed bench for encrypt at default parameters; the bench also plays the public-key memory.
// Builds with or without ENCRYPT_NOISE_EN.
module tb_encrypt;

  localparam int WINDOW = 45;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  plaintext;
  logic [29:0] subset;
`ifdef ENCRYPT_NOISE_EN
  logic signed [3:0] noise;
`endif
  logic [4:0]  pk_addr;
  logic        pk_rd_en;
  logic [19:0] pk_data;
  logic        busy;
  logic        done;
  logic [19:0] cipher_text;

  logic [19:0] pkMem [30];

  int vectorCount = 0;
  int missCount   = 0;

  int          firstDone;
  int          doneCount;
  logic [19:0] ctAtDone;
  logic        busyAt1, rdEnAt1, rdEnAt31;
  logic [4:0]  addrAt1, addrAt5, addrAt31;
  logic        busyAfterRst;
  logic [19:0] ctAfterRst;
  logic [9:0]  exp0, exp1;

  encrypt dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .plaintext   (plaintext),
    .subset      (subset),
`ifdef ENCRYPT_NOISE_EN
    .noise       (noise),
`endif
    .pk_addr     (pk_addr),
    .pk_rd_en    (pk_rd_en),
    .pk_data     (pk_data),
    .busy        (busy),
    .done        (done),
    .cipher_text (cipher_text)
  );

  always #5 clk = ~clk;

  // Public-key memory with one cycle of read latency.
  always @(posedge clk) begin
    if (pk_rd_en) pk_data <= pkMem[pk_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Pulses start, then watches a fixed window of cycles; optionally a second start or a reset mid-run.
  task automatic applyStimulus(input logic [5:0] m, input logic [29:0] sub, input int secondAt, input int rstAt);
    firstDone    = -1;
    doneCount    = 0;
    ctAtDone     = '0;
    busyAfterRst = 1'b1;
    ctAfterRst   = '1;
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b1;
    plaintext = m;
    subset    = sub;
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busyAt1 = busy;
        rdEnAt1 = pk_rd_en;
        addrAt1 = pk_addr;
      end
      if (c == 5) addrAt5 = pk_addr;
      if (c == 31) begin
        rdEnAt31 = pk_rd_en;
        addrAt31 = pk_addr;
      end
      if (done) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = c;
          ctAtDone  = cipher_text;
        end
      end
      if (rstAt > 0 && c == rstAt + 1) begin
        busyAfterRst = busy;
        ctAfterRst   = cipher_text;
        rst          = 1'b0;
      end
      start = (c == secondAt);
      if (c == secondAt) plaintext = 6'd9;
      if (c == rstAt) rst = 1'b1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    subset    = '0;
`ifdef ENCRYPT_NOISE_EN
    noise     = '0;
`endif
    for (int i = 0; i < 30; i++) pkMem[i] = {10'(i * 37 + 11), 10'(1000 - i * 13)};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rd_en", 32'(pk_rd_en), 32'd0);
    checkOutput("reset_addr", 32'(pk_addr), 32'd0);
    checkOutput("reset_ct", 32'(cipher_text), 32'd0);

    // m=0, subset=0; start issued in the first cycle after reset release
    applyStimulus(6'd0, 30'd0, 0, 0);
    checkOutput("zero_latency", 32'(firstDone), 32'd32);
    checkOutput("zero_ct", 32'(ctAtDone), 32'd0);
    checkOutput("zero_done_count", 32'(doneCount), 32'd1);
    checkOutput("run_busy_c1", 32'(busyAt1), 32'd1);
    checkOutput("run_rd_en_c1", 32'(rdEnAt1), 32'd1);
    checkOutput("run_addr_c1", 32'(addrAt1), 32'd0);
    checkOutput("run_addr_c5", 32'(addrAt5), 32'd4);
    checkOutput("drain_rd_en", 32'(rdEnAt31), 32'd0);
    checkOutput("drain_addr", 32'(addrAt31), 32'd0);

    // Row 0 only
    pkMem[0] = {10'd200, 10'd100};
    applyStimulus(6'd5, 30'd1, 0, 0);
    checkOutput("row0_ct", 32'(ctAtDone), 32'({10'd200, 10'd180}));
    checkOutput("row0_latency", 32'(firstDone), 32'd32);
    checkOutput("row0_hold_ct", 32'(cipher_text), 32'({10'd200, 10'd180}));

    // All rows selected, lanes wrap mod 1024
    for (int i = 0; i < 30; i++) pkMem[i] = {10'd1000, 10'd1000};
    applyStimulus(6'd63, 30'h3FFF_FFFF, 0, 0);
    checkOutput("wrap_ct", 32'(ctAtDone), 32'({10'd304, 10'd288}));
    checkOutput("wrap_latency", 32'(firstDone), 32'd32);

    // Sparse subset against a per-row reference sum
    for (int i = 0; i < 30; i++) pkMem[i] = {10'(i * 37 + 11), 10'(1000 - i * 13)};
    exp0 = 10'd672;
    exp1 = 10'd0;
    for (int i = 0; i < 30; i++) begin
      if (((30'h15A3_C96E >> i) & 30'd1) != 30'd0) begin
        exp0 = exp0 + 10'(1000 - i * 13);
        exp1 = exp1 + 10'(i * 37 + 11);
      end
    end
    applyStimulus(6'd42, 30'h15A3_C96E, 0, 0);
    checkOutput("mixed_ct", 32'(ctAtDone), 32'({exp1, exp0}));
    checkOutput("mixed_latency", 32'(firstDone), 32'd32);

    // Second start while busy is ignored
    pkMem[0] = {10'd200, 10'd100};
    applyStimulus(6'd5, 30'd1, 10, 0);
    checkOutput("ignore_done_count", 32'(doneCount), 32'd1);
    checkOutput("ignore_ct", 32'(ctAtDone), 32'({10'd200, 10'd180}));
    checkOutput("ignore_latency", 32'(firstDone), 32'd32);

    // Reset mid-operation aborts, then a new operation completes
    applyStimulus(6'd5, 30'd1, 0, 15);
    checkOutput("abort_busy", 32'(busyAfterRst), 32'd0);
    checkOutput("abort_ct", 32'(ctAfterRst), 32'd0);
    checkOutput("abort_done_count", 32'(doneCount), 32'd0);
    applyStimulus(6'd7, 30'd1, 0, 0);
    checkOutput("post_abort_ct", 32'(ctAtDone), 32'({10'd200, 10'd212}));
    checkOutput("post_abort_latency", 32'(firstDone), 32'd32);

    // Lane 0 initial value with or without noise
`ifdef ENCRYPT_NOISE_EN
    noise = -4'sd3;
    applyStimulus(6'd1, 30'd0, 0, 0);
    checkOutput("noise_ct", 32'(ctAtDone), 32'({10'd0, 10'd13}));
`else
    applyStimulus(6'd1, 30'd0, 0, 0);
    checkOutput("noise_ct", 32'(ctAtDone), 32'({10'd0, 10'd16}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
